// File: rtl/rst_seq_pkg.sv
// Shared constants for the reset sequencer: FSM state encoding, event counter
// width and the counter-width helper.
package rst_seq_pkg;

    localparam logic [1:0] ST_ASSERT = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;

    localparam int RST_EVT_W = 8;

    // Width of a down/up counter that must hold values 0..n-1, never below 1.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// Deassertion synchronizer for the raw reset: asynchronously set, releases
// through SYNC_STAGES flops by shifting in zeros.
module rst_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic sync_rst
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign sync_rst = chain[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: async assert, synchronous release after a programmable hold,
// filtered soft-reset request. Optional event counter under RST_SEQ_CNT_EN.
module rst_seq_gen
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int REQ_FILTER  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ext_req,
    output logic                 rst_out,
    output logic                 ready,
`ifdef RST_SEQ_CNT_EN
    output logic [RST_EVT_W-1:0] rst_events,
`endif
    output logic [1:0]           state_dbg
);

    localparam int HW = cnt_w(HOLD_CYCLES);
    localparam int FW = cnt_w(REQ_FILTER);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(REQ_FILTER - 1);

    logic          sync_rst;
    logic [1:0]    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [FW-1:0] filt_cnt, filt_nxt;

    rst_sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sync_rst (sync_rst)
    );

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        filt_nxt  = filt_cnt;
        case (state)
            ST_ASSERT: begin
                filt_nxt = '0;
                if (!sync_rst) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                // A request during hold extends it rather than letting it expire.
                if (ext_req) begin
                    hold_nxt = HOLD_LOAD;
                end else if (hold_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_nxt = hold_cnt - 1'b1;
                end
            end
            ST_RUN: begin
                if (!ext_req) begin
                    filt_nxt = '0;
                end else if (filt_cnt == FILT_LAST) begin
                    state_nxt = ST_HOLD;
                    hold_nxt  = HOLD_LOAD;
                    filt_nxt  = '0;
                end else begin
                    filt_nxt = filt_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                hold_nxt  = '0;
                filt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ASSERT;
            hold_cnt <= '0;
            filt_cnt <= '0;
            rst_out  <= 1'b1;
            ready    <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            filt_cnt <= filt_nxt;
            rst_out  <= (state_nxt != ST_RUN);
            ready    <= (state_nxt == ST_RUN);
        end
    end

    assign state_dbg = state;

`ifdef RST_SEQ_CNT_EN
    logic [RST_EVT_W-1:0] evt_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_cnt <= '0;
        end else if (state == ST_RUN && state_nxt == ST_HOLD && evt_cnt != '1) begin
            evt_cnt <= evt_cnt + 1'b1;
        end
    end

    assign rst_events = evt_cnt;
`endif

endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen with default parameters; event counter checks are
// active when RST_SEQ_CNT_EN is defined.
module tb_rst_seq_gen;
    import rst_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ext_req = 1'b0;
    logic       rst_out;
    logic       ready;
    logic [1:0] state_dbg;
`ifdef RST_SEQ_CNT_EN
    logic [7:0] rst_events;
    int         evt_exp = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    rst_seq_gen dut (
        .clk        (clk),
        .reset      (reset),
        .ext_req    (ext_req),
        .rst_out    (rst_out),
        .ready      (ready),
`ifdef RST_SEQ_CNT_EN
        .rst_events (rst_events),
`endif
        .state_dbg  (state_dbg)
    );

    // Driver: present ext_req, let one rising edge pass, land 1 ns after it.
    task automatic tick(input logic req);
        ext_req = req;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [1:0] exp_v;
        reset = 1'b1;
        #1;
        n_checks++;
        if (rst_out !== 1'b1 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: rst_out,ready=%b%b required 10", rst_out, ready);
        end
        n_checks++;
        if (state_dbg !== ST_ASSERT) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d required %0d", state_dbg, ST_ASSERT);
        end
`ifdef RST_SEQ_CNT_EN
        n_checks++;
        if (rst_events !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_events: rst_events=%0d required 0", rst_events);
        end
`endif
        for (int e = 1; e <= 3; e++) begin
            exp_q.push_back(2'b10);
            tick(1'b0);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({rst_out, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL reset_held edge %0d: rst_out,ready=%b%b required %b", e, rst_out, ready, exp_v);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_power_up();
        logic       exp_rst;
        logic [1:0] exp_v;
        for (int e = 1; e <= 22; e++) begin
            exp_rst = (e < 19);
            exp_q.push_back({exp_rst, ~exp_rst});
            tick(1'b0);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({rst_out, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL power_up edge %0d: rst_out,ready=%b%b required %b", e, rst_out, ready, exp_v);
            end
            if (e == 2 || e == 3) begin
                n_checks++;
                if (state_dbg !== ((e == 2) ? ST_ASSERT : ST_HOLD)) begin
                    n_fail++;
                    $display("FAIL power_up_state edge %0d: state=%0d", e, state_dbg);
                end
            end
        end
    endtask

    task automatic test_soft_reset();
        logic       exp_rst;
        logic [1:0] exp_v;
        for (int e = 1; e <= 22; e++) begin
            exp_rst = (e >= 4 && e < 20);
            exp_q.push_back({exp_rst, ~exp_rst});
            tick(e <= 4);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({rst_out, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL soft_reset edge %0d: rst_out,ready=%b%b required %b", e, rst_out, ready, exp_v);
            end
        end
`ifdef RST_SEQ_CNT_EN
        evt_exp++;
        n_checks++;
        if (rst_events !== 8'(evt_exp)) begin
            n_fail++;
            $display("FAIL soft_reset_events: rst_events=%0d required %0d", rst_events, evt_exp);
        end
`endif
    endtask

    task automatic test_filter_reject();
        logic [9:0] pat;
        logic [1:0] exp_v;
        int         k;
        pat = 10'b00_0111_0111;
        for (int e = 0; e < 10; e++) begin
            exp_q.push_back(2'b01);
            tick(pat[e]);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({rst_out, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL filter_reject edge %0d: rst_out,ready=%b%b required %b", e, rst_out, ready, exp_v);
            end
        end
        for (int r = 0; r < 4; r++) begin
            k = $urandom_range(1, 3);
            for (int e = 0; e <= k; e++) begin
                exp_q.push_back(2'b01);
                tick(e < k);
                exp_v = exp_q.pop_front();
                n_checks++;
                if ({rst_out, ready} !== exp_v) begin
                    n_fail++;
                    $display("FAIL filter_random run %0d len %0d: rst_out,ready=%b%b required %b", r, k, rst_out, ready, exp_v);
                end
            end
        end
`ifdef RST_SEQ_CNT_EN
        n_checks++;
        if (rst_events !== 8'(evt_exp)) begin
            n_fail++;
            $display("FAIL filter_events: rst_events=%0d required %0d", rst_events, evt_exp);
        end
`endif
    endtask

    task automatic test_hold_extension();
        logic       exp_rst;
        logic [1:0] exp_v;
        int         len;
        for (int p = 0; p < 2; p++) begin
            len = (p == 0) ? 10 : int'($urandom_range(1, 6));
            for (int e = 1; e <= 4 + len + 18; e++) begin
                exp_rst = (e >= 4 && e < 4 + len + 16);
                exp_q.push_back({exp_rst, ~exp_rst});
                tick(e <= 4 + len);
                exp_v = exp_q.pop_front();
                n_checks++;
                if ({rst_out, ready} !== exp_v) begin
                    n_fail++;
                    $display("FAIL hold_ext len %0d edge %0d: rst_out,ready=%b%b required %b", len, e, rst_out, ready, exp_v);
                end
            end
`ifdef RST_SEQ_CNT_EN
            evt_exp++;
`endif
        end
`ifdef RST_SEQ_CNT_EN
        n_checks++;
        if (rst_events !== 8'(evt_exp)) begin
            n_fail++;
            $display("FAIL hold_ext_events: rst_events=%0d required %0d", rst_events, evt_exp);
        end
`endif
    endtask

    task automatic test_mid_hold_reset();
        logic       exp_rst;
        logic [1:0] exp_v;
        // Trigger, then stop 8 edges into hold so the hold counter sits at 7.
        for (int e = 1; e <= 12; e++) begin
            exp_rst = (e >= 4);
            exp_q.push_back({exp_rst, ~exp_rst});
            tick(e <= 4);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({rst_out, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL mid_hold_pre edge %0d: rst_out,ready=%b%b required %b", e, rst_out, ready, exp_v);
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (rst_out !== 1'b1 || ready !== 1'b0 || state_dbg !== ST_ASSERT) begin
            n_fail++;
            $display("FAIL mid_hold_async: rst_out,ready,state=%b%b%0d required 10%0d", rst_out, ready, state_dbg, ST_ASSERT);
        end
`ifdef RST_SEQ_CNT_EN
        evt_exp = 0;
        n_checks++;
        if (rst_events !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_hold_events_clr: rst_events=%0d required 0", rst_events);
        end
`endif
        #4;
        reset = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            exp_rst = (e < 19);
            exp_q.push_back({exp_rst, ~exp_rst});
            tick(1'b0);
            exp_v = exp_q.pop_front();
            n_checks++;
            if ({rst_out, ready} !== exp_v) begin
                n_fail++;
                $display("FAIL mid_hold_release edge %0d: rst_out,ready=%b%b required %b", e, rst_out, ready, exp_v);
            end
        end
`ifdef RST_SEQ_CNT_EN
        n_checks++;
        if (rst_events !== 8'd0) begin
            n_fail++;
            $display("FAIL mid_hold_events: rst_events=%0d required 0", rst_events);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic       exp_rst;
        logic [1:0] exp_v;
        int         n_runs;
`ifdef RST_SEQ_CNT_EN
        n_runs = 260;
`else
        n_runs = 3;
`endif
        for (int c = 0; c < n_runs; c++) begin
            for (int e = 1; e <= 20; e++) begin
                exp_rst = (e >= 4 && e < 20);
                exp_q.push_back({exp_rst, ~exp_rst});
                tick(e <= 4);
                exp_v = exp_q.pop_front();
                n_checks++;
                if ({rst_out, ready} !== exp_v) begin
                    n_fail++;
                    $display("FAIL back_to_back run %0d edge %0d: rst_out,ready=%b%b required %b", c, e, rst_out, ready, exp_v);
                end
            end
`ifdef RST_SEQ_CNT_EN
            if (evt_exp < 255) evt_exp++;
            n_checks++;
            if (rst_events !== 8'(evt_exp)) begin
                n_fail++;
                $display("FAIL back_to_back_events run %0d: rst_events=%0d required %0d", c, rst_events, evt_exp);
            end
`endif
        end
`ifdef RST_SEQ_CNT_EN
        n_checks++;
        if (rst_events !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: rst_events=%0d required 255", rst_events);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_soft_reset();
        test_filter_reject();
        test_hold_extension();
        test_mid_hold_reset();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
